// File: rtl/maquina_ctrl_n_pkg.sv
// ============================================================================
// Module      : maquina_pkg
// Description : Shared state encoding and helpers for the FIFO-bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maquina_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET  = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Mask with the low n bits set, used for the "every FIFO empty" compare.
  function automatic logic [31:0] ones(input int n);
    if (n >= 32) begin
      return '1;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maquina_ctrl_n_if.sv
// ============================================================================
// Module      : maquina_ctrl_n_if
// Description : Config/FIFO-bank bundle of the controller. ERR_COUNT_EN adds
//               the err_count status field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maquina_ctrl_n_if
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 4
);

  logic [UMBRAL_W-1:0]  umbralMF;
  logic [UMBRAL_W-1:0]  umbralVC;
  logic [UMBRAL_W-1:0]  umbralD;
  logic [NUM_FIFOS-1:0] Fifo_empties;
  logic [NUM_FIFOS-1:0] Fifo_errors;

  logic                 init_out;
  logic                 idle_out;
  logic                 active_out;
  logic                 error_out;
  logic [UMBRAL_W-1:0]  umbralMF_out;
  logic [UMBRAL_W-1:0]  umbralVC_out;
  logic [UMBRAL_W-1:0]  umbralD_out;
  logic [NUM_FIFOS-1:0] err_src;
  logic [STATE_W-1:0]   state;
  logic [STATE_W-1:0]   next_state;
`ifdef ERR_COUNT_EN
  logic [7:0]           err_count;
`endif

  modport master (
    output umbralMF, umbralVC, umbralD, Fifo_empties, Fifo_errors,
    input  init_out, idle_out, active_out, error_out,
    input  umbralMF_out, umbralVC_out, umbralD_out, err_src,
`ifdef ERR_COUNT_EN
    input  err_count,
`endif
    input  state, next_state
  );

  modport slave (
    input  umbralMF, umbralVC, umbralD, Fifo_empties, Fifo_errors,
    output init_out, idle_out, active_out, error_out,
    output umbralMF_out, umbralVC_out, umbralD_out, err_src,
`ifdef ERR_COUNT_EN
    output err_count,
`endif
    output state, next_state
  );

endinterface

`default_nettype wire

// File: rtl/maquina_ctrl_n_err_hold_counter.sv
// ============================================================================
// Module      : err_hold_counter
// Description : Counts consecutive clean cycles; done flags the last one needed
//               to leave ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module err_hold_counter #(
  parameter int ERR_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic clean,
  output logic done
);

  localparam int             C_CW   = $clog2(ERR_HOLD + 1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(ERR_HOLD - 1);
  localparam logic [C_CW-1:0] C_MAX  = C_CW'(ERR_HOLD);

  logic [C_CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || !clean) begin
      r_cnt <= '0;
    end else if (r_cnt != C_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign done = !clear && clean && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/maquina_ctrl_n.sv
// ============================================================================
// Module      : maquina_ctrl_n
// Description : FIFO-bank supervisor FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with
//               threshold latching and error-source capture. ERR_COUNT_EN
//               adds a saturating count of ERROR entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_ctrl_n
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 4,
  parameter int ERR_HOLD  = 4
) (
  input  logic            clk,
  input  logic            reset,
  maquina_ctrl_n_if.slave bus
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_any_umbral;
  logic                 w_any_err;
  logic                 w_all_empty;
  logic                 w_enter_err;
  logic                 w_hold_done;
  logic                 r_init;
  logic [UMBRAL_W-1:0]  r_mf;
  logic [UMBRAL_W-1:0]  r_vc;
  logic [UMBRAL_W-1:0]  r_d;
  logic [NUM_FIFOS-1:0] r_err_src;

  assign w_any_umbral = |{bus.umbralMF, bus.umbralVC, bus.umbralD};
  assign w_any_err    = |bus.Fifo_errors;
  assign w_all_empty  = (32'(bus.Fifo_empties) == ones(NUM_FIFOS));
  assign w_enter_err  = (r_state != ERROR) && (w_next == ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = RESET;
    case (r_state)
      RESET:  w_next = INIT;
      INIT:   w_next = w_any_umbral ? IDLE : INIT;
      IDLE:   begin
        if (w_any_err)         w_next = ERROR;
        else if (!w_all_empty) w_next = ACTIVE;
        else                   w_next = IDLE;
      end
      ACTIVE: begin
        if (w_any_err)         w_next = ERROR;
        else if (w_all_empty)  w_next = IDLE;
        else                   w_next = ACTIVE;
      end
      ERROR:  w_next = w_hold_done ? RESET : ERROR;
      default: w_next = RESET;
    endcase
  end

  // Entry overwrites err_src so it only reflects the current episode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init    <= 1'b0;
      r_mf      <= '0;
      r_vc      <= '0;
      r_d       <= '0;
      r_err_src <= '0;
    end else begin
      r_init <= 1'b0;
      if (r_state == INIT && w_any_umbral) begin
        r_init <= 1'b1;
        r_mf   <= bus.umbralMF;
        r_vc   <= bus.umbralVC;
        r_d    <= bus.umbralD;
      end
      if (w_enter_err) begin
        r_err_src <= bus.Fifo_errors;
      end else if (r_state == ERROR) begin
        r_err_src <= r_err_src | bus.Fifo_errors;
      end
    end
  end

  err_hold_counter #(
    .ERR_HOLD (ERR_HOLD)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != ERROR),
    .clean (!w_any_err),
    .done  (w_hold_done)
  );

`ifdef ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_enter_err && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.err_count = r_err_count;
`endif

  assign bus.state        = r_state;
  assign bus.next_state   = w_next;
  assign bus.init_out     = r_init;
  assign bus.idle_out     = (r_state == IDLE);
  assign bus.active_out   = (r_state == ACTIVE);
  assign bus.error_out    = (r_state == ERROR);
  assign bus.umbralMF_out = r_mf;
  assign bus.umbralVC_out = r_vc;
  assign bus.umbralD_out  = r_d;
  assign bus.err_src      = r_err_src;

endmodule

`default_nettype wire

// File: tb/tb_maquina_ctrl_n.sv
// ============================================================================
// Module      : tb_maquina_ctrl_n
// Description : Scoreboard bench for maquina_ctrl_n (directed + random phases).
//               Checks err_count when ERR_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maquina_ctrl_n;

  localparam int N    = 5;
  localparam int W    = 4;
  localparam int HOLD = 4;
  localparam logic [N-1:0] ALL = '1;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maquina_ctrl_n_if #(.NUM_FIFOS(N), .UMBRAL_W(W)) bus ();

  maquina_ctrl_n #(.NUM_FIFOS(N), .UMBRAL_W(W), .ERR_HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int           st;
    int           nx;
    bit           init;
    logic [W-1:0] mf, vc, d;
    logic [N-1:0] src;
    int           cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 1'b0;

  // Reference model state: clean-cycle count instead of a hold counter.
  int           m_st, m_clean, m_cnt;
  bit           m_init;
  logic [W-1:0] m_mf, m_vc, m_d;
  logic [N-1:0] m_src;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int st, input logic [N-1:0] emp,
                                    input logic [N-1:0] err, input bit any_u,
                                    input int clean);
    case (st)
      S_RESET: return S_INIT;
      S_INIT:  return any_u ? S_IDLE : S_INIT;
      S_IDLE, S_ACTIVE: begin
        if (err != 0)   return S_ERROR;
        if (emp != ALL) return S_ACTIVE;
        return S_IDLE;
      end
      S_ERROR: return (err == 0 && clean + 1 >= HOLD) ? S_RESET : S_ERROR;
      default: return S_RESET;
    endcase
  endfunction

  function automatic bit any_umbral();
    return (bus.umbralMF != 0) || (bus.umbralVC != 0) || (bus.umbralD != 0);
  endfunction

  task automatic model_reset();
    m_st = S_RESET; m_clean = 0; m_cnt = 0; m_init = 0;
    m_mf = '0; m_vc = '0; m_d = '0; m_src = '0;
  endtask

  task automatic model_edge();
    int nx;
    if (reset) begin
      model_reset();
      return;
    end
    nx = model_next(m_st, bus.Fifo_empties, bus.Fifo_errors, any_umbral(), m_clean);
    m_init = 0;
    if (m_st == S_INIT && nx == S_IDLE) begin
      m_init = 1;
      m_mf = bus.umbralMF; m_vc = bus.umbralVC; m_d = bus.umbralD;
    end
    if (m_st != S_ERROR && nx == S_ERROR) begin
      m_src   = bus.Fifo_errors;
      m_clean = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_st == S_ERROR) begin
      m_src   = m_src | bus.Fifo_errors;
      m_clean = (bus.Fifo_errors == 0) ? m_clean + 1 : 0;
    end
    m_st = nx;
  endtask

  task automatic cyc(input bit r, input logic [W-1:0] mf, input logic [W-1:0] vc,
                     input logic [W-1:0] d, input logic [N-1:0] emp, input logic [N-1:0] err);
    exp_t e;
    @(posedge clk);
    model_edge();
    #2;
    reset = r;
    bus.umbralMF = mf; bus.umbralVC = vc; bus.umbralD = d;
    bus.Fifo_empties = emp; bus.Fifo_errors = err;
    if (r) model_reset();
    e.st = m_st; e.init = m_init; e.mf = m_mf; e.vc = m_vc; e.d = m_d;
    e.src = m_src; e.cnt = m_cnt;
    e.nx = model_next(m_st, emp, err, (mf != 0) || (vc != 0) || (d != 0), m_clean);
    sb.push_back(e);
  endtask

  // Monitor: compares every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (!drv_done) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: got 0 entries expected >=1 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("state",        32'(bus.state),        e.st);
          chk("next_state",   32'(bus.next_state),   e.nx);
          chk("init_out",     32'(bus.init_out),     32'(e.init));
          chk("idle_out",     32'(bus.idle_out),     32'(e.st == S_IDLE));
          chk("active_out",   32'(bus.active_out),   32'(e.st == S_ACTIVE));
          chk("error_out",    32'(bus.error_out),    32'(e.st == S_ERROR));
          chk("umbralMF_out", 32'(bus.umbralMF_out), 32'(e.mf));
          chk("umbralVC_out", 32'(bus.umbralVC_out), 32'(e.vc));
          chk("umbralD_out",  32'(bus.umbralD_out),  32'(e.d));
          chk("err_src",      32'(bus.err_src),      32'(e.src));
`ifdef ERR_COUNT_EN
          chk("err_count",    32'(bus.err_count),    e.cnt);
`endif
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.umbralMF = '0; bus.umbralVC = '0; bus.umbralD = '0;
    bus.Fifo_empties = ALL; bus.Fifo_errors = '0;
    model_reset();

    repeat (2) cyc(1, 0, 0, 0, ALL, 0);
    // Bring-up with MF only, then input changes in IDLE must not reload.
    repeat (2) cyc(0, 3, 0, 0, ALL, 0);
    repeat (3) cyc(0, 7, 0, 0, ALL, 0);

    // Zero thresholds keep the FSM in INIT.
    cyc(1, 0, 0, 0, ALL, 0);
    repeat (12) cyc(0, 0, 0, 0, ALL, 0);
    repeat (2) cyc(0, 0, 0, 5, ALL, 0);

    // IDLE <-> ACTIVE on the empties vector.
    cyc(0, 0, 0, 5, 5'b11011, 0);
    repeat (2) cyc(0, 0, 0, 5, ALL, 0);

    // ACTIVE -> ERROR, accumulate sources, broken then completed clean hold.
    cyc(0, 0, 0, 5, 5'b11011, 0);
    cyc(0, 0, 0, 5, 5'b11011, 5'b00100);
    cyc(0, 0, 0, 5, 5'b11011, 5'b01000);
    repeat (2) cyc(0, 0, 0, 5, 5'b11011, 0);
    cyc(0, 0, 0, 5, 5'b11011, 5'b01000);
    repeat (6) cyc(0, 0, 0, 5, ALL, 0);

    // Error beats activity in IDLE, then async reset while in ERROR.
    cyc(0, 0, 0, 5, 5'b10111, 5'b00010);
    cyc(0, 0, 0, 5, ALL, 0);
    cyc(1, 0, 0, 5, ALL, 0);
    cyc(1, 0, 0, 5, ALL, 0);
    repeat (2) cyc(0, 0, 9, 0, ALL, 0);

    // Many short ERROR episodes (drives err_count into saturation).
    for (int ep = 0; ep < 300; ep++) begin
      cyc(0, 1, 2, 3, ALL, N'($urandom_range(1, (1 << N) - 1)));
      repeat (HOLD) cyc(0, 1, 2, 3, ALL, 0);
      repeat (2) cyc(0, 1, 2, 3, ALL, 0);
    end

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] mf, vc, d;
      logic [N-1:0] emp, err;
      mf  = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      vc  = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      d   = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      emp = ($urandom_range(0, 1) == 0) ? ALL : N'($urandom);
      err = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cyc(($urandom_range(0, 199) == 0), mf, vc, d, emp, err);
    end

    #2;
    drv_done = 1'b1;
    @(posedge clk);
    #4;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
